// File: rtl/timer_core_pkg.sv
// Shared state encoding, limits and preset clamp helpers
// for the two-mode mm:ss timer.
package timer_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [5:0] SEC_MAX   = 6'd59;
  localparam logic       MODE_UP   = 1'b0;
  localparam logic       MODE_DOWN = 1'b1;

  function automatic logic [6:0] clamp_min(
    input logic [6:0] v,
    input logic [6:0] lim
  );
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [5:0] clamp_sec(
    input logic [5:0] v
  );
    return (v > SEC_MAX) ? SEC_MAX : v;
  endfunction

endpackage

// File: rtl/timer_core_sec_tick_gen.sv
// One-second tick divider; runs only while enabled and
// restarts from zero whenever the enable drops.
module sec_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic Clk,
  input  logic RstN,
  input  logic En,
  output logic Tick
);

  localparam int W =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == LAST);
  assign Tick   = En & w_last;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_cnt <= '0;
    end else if (!En || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_core.sv
// Counting engine of the two-mode timer: elapsed mm:ss
// counter, run/pause FSM and remaining-time display path.
module timer_core
  import timer_core_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int MAX_MIN  = 99
) (
  input  logic       Clk,
  input  logic       RstN,
  input  logic       StartStop,
  input  logic       Clear,
  input  logic       ModeIn,
  input  logic [6:0] PresetMin,
  input  logic [5:0] PresetSec,
  output logic [7:0] MSBBinary,
  output logic [7:0] LSBBinary,
  output logic       ModeSel,
  output logic       Running,
  output logic       Done
);

  localparam logic [6:0] MIN_MAX = 7'(MAX_MIN);

  logic r_ss;
  logic r_clr;
  logic w_ss_ev;
  logic w_clr_ev;

  assign w_ss_ev  = StartStop & ~r_ss;
  assign w_clr_ev = Clear & ~r_clr;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_ss  <= 1'b0;
      r_clr <= 1'b0;
    end else begin
      r_ss  <= StartStop;
      r_clr <= Clear;
    end
  end

  state_t     r_state;
  state_t     w_nstate;
  logic [6:0] r_min;
  logic [6:0] w_nmin;
  logic [5:0] r_sec;
  logic [5:0] w_nsec;
  logic       r_mode;
  logic       w_nmode;
  logic [6:0] r_pmin;
  logic [6:0] w_npmin;
  logic [5:0] r_psec;
  logic [5:0] w_npsec;

  logic       w_run_st;
  logic       w_tick;

  assign w_run_st = (r_state == ST_RUN);

  sec_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .Clk  (Clk),
    .RstN (RstN),
    .En   (w_run_st),
    .Tick (w_tick)
  );

  logic [6:0] w_cmin;
  logic [5:0] w_csec;
  logic       w_czero;

  assign w_cmin  = clamp_min(PresetMin, MIN_MAX);
  assign w_csec  = clamp_sec(PresetSec);
  assign w_czero = (w_cmin == 7'd0) && (w_csec == 6'd0);

  logic       w_wrap;
  logic [6:0] w_imin;
  logic [5:0] w_isec;
  logic       w_term;

  assign w_wrap = (r_sec == SEC_MAX);
  assign w_isec = w_wrap ? 6'd0 : r_sec + 6'd1;
  assign w_imin = w_wrap ? r_min + 7'd1 : r_min;

  // Down mode stops at the latched preset, up mode at the ceiling.
  assign w_term = (r_mode == MODE_DOWN)
    ? ((w_imin == r_pmin) && (w_isec == r_psec))
    : ((w_imin == MIN_MAX) && (w_isec == SEC_MAX));

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_state <= ST_IDLE;
      r_min   <= '0;
      r_sec   <= '0;
      r_mode  <= MODE_UP;
      r_pmin  <= '0;
      r_psec  <= '0;
    end else begin
      r_state <= w_nstate;
      r_min   <= w_nmin;
      r_sec   <= w_nsec;
      r_mode  <= w_nmode;
      r_pmin  <= w_npmin;
      r_psec  <= w_npsec;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_nmin   = r_min;
    w_nsec   = r_sec;
    w_nmode  = r_mode;
    w_npmin  = r_pmin;
    w_npsec  = r_psec;
    if (w_clr_ev) begin
      w_nstate = ST_IDLE;
      w_nmin   = '0;
      w_nsec   = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_nmin  = '0;
          w_nsec  = '0;
          w_nmode = ModeIn;
          if (w_ss_ev) begin
            w_npmin  = w_cmin;
            w_npsec  = w_csec;
            w_nstate = ((ModeIn == MODE_DOWN) && w_czero)
              ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_tick) begin
            w_nmin = w_imin;
            w_nsec = w_isec;
          end
          if (w_tick && w_term) begin
            w_nstate = ST_DONE;
          end else if (w_ss_ev) begin
            w_nstate = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (w_ss_ev) begin
            w_nstate = ST_RUN;
          end
        end
        ST_DONE: begin
          w_nstate = ST_DONE;
        end
      endcase
    end
  end

  logic [6:0] w_rmin;
  logic [5:0] w_rsec;

  // Remaining = preset - elapsed; elapsed never exceeds preset.
  always_comb begin
    if (r_psec >= r_sec) begin
      w_rsec = r_psec - r_sec;
      w_rmin = r_pmin - r_min;
    end else begin
      w_rsec = 6'(7'(r_psec) + 7'd60 - 7'(r_sec));
      w_rmin = r_pmin - r_min - 7'd1;
    end
  end

  logic [7:0] r_msb;
  logic [7:0] r_lsb;
  logic       r_modesel;
  logic       r_running;
  logic       r_done;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_msb     <= '0;
      r_lsb     <= '0;
      r_modesel <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_msb <= '0;
        r_lsb <= '0;
      end else if (r_mode == MODE_DOWN) begin
        r_msb <= {1'b0, w_rmin};
        r_lsb <= {2'b0, w_rsec};
      end else begin
        r_msb <= {1'b0, r_min};
        r_lsb <= {2'b0, r_sec};
      end
      r_modesel <= r_mode;
      r_running <= (r_state == ST_RUN);
      r_done    <= (r_state == ST_DONE);
    end
  end

  assign MSBBinary = r_msb;
  assign LSBBinary = r_lsb;
  assign ModeSel   = r_modesel;
  assign Running   = r_running;
  assign Done      = r_done;

endmodule

// File: tb/tb_timer_core.sv
// Bench for timer_core: reference model in total seconds,
// scenario table, corner sequences and random stimulus.
module tb_timer_core;

  localparam int TD = 4;
  localparam int MM = 99;

  logic       Clk = 1'b0;
  logic       RstN = 1'b0;
  logic       StartStop = 1'b0;
  logic       Clear = 1'b0;
  logic       ModeIn = 1'b0;
  logic [6:0] PresetMin = '0;
  logic [5:0] PresetSec = '0;
  logic [7:0] MSBBinary;
  logic [7:0] LSBBinary;
  logic       ModeSel;
  logic       Running;
  logic       Done;

  always #5 Clk = ~Clk;

  timer_core #(
    .TICK_DIV (TD),
    .MAX_MIN  (MM)
  ) dut (
    .Clk       (Clk),
    .RstN      (RstN),
    .StartStop (StartStop),
    .Clear     (Clear),
    .ModeIn    (ModeIn),
    .PresetMin (PresetMin),
    .PresetSec (PresetSec),
    .MSBBinary (MSBBinary),
    .LSBBinary (LSBBinary),
    .ModeSel   (ModeSel),
    .Running   (Running),
    .Done      (Done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // phase: 0 idle, 1 run, 2 pause, 3 done; times in total seconds
  int m_phase, m_el, m_pre, m_mode, m_cyc, m_pss, m_pclr;
  int e_msb, e_lsb, e_run, e_done, e_mode;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_el = 0; m_pre = 0; m_mode = 0;
    m_cyc = 0; m_pss = 0; m_pclr = 0;
    e_msb = 0; e_lsb = 0; e_run = 0; e_done = 0; e_mode = 0;
  endtask

  task automatic model_step();
    int rem, tick, ssev, clev, ncyc, cap, pm, ps;
    if (m_phase == 0) begin
      e_msb = 0; e_lsb = 0;
    end else begin
      rem = m_mode ? (m_pre - m_el) : m_el;
      e_msb = rem / 60; e_lsb = rem % 60;
    end
    e_run  = (m_phase == 1);
    e_done = (m_phase == 3);
    e_mode = m_mode;
    ssev = (StartStop && !m_pss);
    clev = (Clear && !m_pclr);
    m_pss = StartStop; m_pclr = Clear;
    tick = (m_phase == 1 && m_cyc == TD - 1);
    ncyc = (m_phase == 1 && !tick) ? m_cyc + 1 : 0;
    cap = MM * 60 + 59;
    if (clev) begin
      m_phase = 0; m_el = 0;
    end else begin
      case (m_phase)
        0: begin
          m_el = 0;
          m_mode = ModeIn;
          if (ssev) begin
            pm = (PresetMin > MM) ? MM : PresetMin;
            ps = (PresetSec > 59) ? 59 : PresetSec;
            m_pre = pm * 60 + ps;
            m_phase = (ModeIn && m_pre == 0) ? 3 : 1;
          end
        end
        1: begin
          if (tick) m_el++;
          if (tick && (m_mode ? m_el == m_pre : m_el == cap))
            m_phase = 3;
          else if (ssev)
            m_phase = 2;
        end
        2: if (ssev) m_phase = 1;
        default: ;
      endcase
    end
    m_cyc = ncyc;
  endtask

  task automatic check_model();
    chk("model_msb", MSBBinary, e_msb);
    chk("model_lsb", LSBBinary, e_lsb);
    chk("model_run", Running, e_run);
    chk("model_done", Done, e_done);
    chk("model_mode", ModeSel, e_mode);
  endtask

  task automatic cyc(input logic ss, input logic clr,
                     input logic md, input logic [6:0] pm,
                     input logic [5:0] ps);
    StartStop = ss; Clear = clr; ModeIn = md;
    PresetMin = pm; PresetSec = ps;
    @(posedge Clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge Clk);
    RstN = 1'b0; StartStop = 1'b0; Clear = 1'b0;
    model_reset();
    @(negedge Clk);
    RstN = 1'b1;
  endtask

  typedef struct {
    logic       mode;
    logic [6:0] pm;
    logic [5:0] ps;
    int         n;
    int         msb;
    int         lsb;
    logic       run;
    logic       done;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{1'b0, 7'd0,   6'd0,  245,  1,  1, 1'b1, 1'b0};
    vt[1] = '{1'b1, 7'd0,   6'd3,  13,   0,  0, 1'b0, 1'b1};
    vt[2] = '{1'b1, 7'd2,   6'd0,  5,    1, 59, 1'b1, 1'b0};
    vt[3] = '{1'b1, 7'd127, 6'd63, 1,   99, 59, 1'b1, 1'b0};
    vt[4] = '{1'b1, 7'd0,   6'd0,  1,    0,  0, 1'b0, 1'b1};
    vt[5] = '{1'b0, 7'd9,   6'd9,  1,    0,  0, 1'b1, 1'b0};
    vt[6] = '{1'b1, 7'd5,   6'd30, 125,  4, 59, 1'b1, 1'b0};

    model_reset();
    #12;
    chk("reset_msb", MSBBinary, 0);
    chk("reset_lsb", LSBBinary, 0);
    chk("reset_run", Running, 0);
    chk("reset_done", Done, 0);
    chk("reset_mode", ModeSel, 0);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      cyc(1'b1, 1'b0, vt[i].mode, vt[i].pm, vt[i].ps);
      repeat (vt[i].n)
        cyc(1'b0, 1'b0, vt[i].mode, vt[i].pm, vt[i].ps);
      chk($sformatf("vec%0d_msb", i), MSBBinary, vt[i].msb);
      chk($sformatf("vec%0d_lsb", i), LSBBinary, vt[i].lsb);
      chk($sformatf("vec%0d_run", i), Running, vt[i].run);
      chk($sformatf("vec%0d_done", i), Done, vt[i].done);
      chk($sformatf("vec%0d_mode", i), ModeSel, vt[i].mode);
    end

    // countdown 00:03 reads 3,2,1,0 then ignores StartStop
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 7'd0, 6'd3);
    for (int k = 0; k < 4; k++) begin
      repeat ((k == 0) ? 1 : 4) cyc(1'b0, 1'b0, 1'b1, 7'd0, 6'd3);
      chk("down_lsb", LSBBinary, 3 - k);
    end
    chk("down_done", Done, 1);
    chk("down_run", Running, 0);
    cyc(1'b1, 1'b0, 1'b1, 7'd0, 6'd3);
    repeat (10) cyc(1'b0, 1'b0, 1'b1, 7'd0, 6'd3);
    chk("down_hold_done", Done, 1);
    chk("down_hold_lsb", LSBBinary, 0);

    // pause after two ticks, resume takes TICK_DIV cycles
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 7'd0, 6'd0);
    repeat (8) cyc(1'b0, 1'b0, 1'b0, 7'd0, 6'd0);
    cyc(1'b1, 1'b0, 1'b0, 7'd0, 6'd0);
    repeat (20) cyc(1'b0, 1'b0, 1'b0, 7'd0, 6'd0);
    chk("pause_lsb", LSBBinary, 2);
    chk("pause_run", Running, 0);
    cyc(1'b1, 1'b0, 1'b0, 7'd0, 6'd0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 7'd0, 6'd0);
    chk("resume_pre_lsb", LSBBinary, 2);
    cyc(1'b0, 1'b0, 1'b0, 7'd0, 6'd0);
    chk("resume_lsb", LSBBinary, 3);

    // clear beats StartStop; ModeSel tracks ModeIn only in IDLE
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 7'd0, 6'd0);
    repeat (10) cyc(1'b0, 1'b0, 1'b0, 7'd0, 6'd0);
    cyc(1'b1, 1'b1, 1'b0, 7'd0, 6'd0);
    cyc(1'b0, 1'b0, 1'b0, 7'd0, 6'd0);
    chk("clr_lsb", LSBBinary, 0);
    chk("clr_msb", MSBBinary, 0);
    chk("clr_run", Running, 0);
    repeat (2) cyc(1'b0, 1'b0, 1'b1, 7'd0, 6'd10);
    chk("idle_modesel", ModeSel, 1);
    cyc(1'b1, 1'b0, 1'b1, 7'd0, 6'd10);
    repeat (6) cyc(1'b0, 1'b0, 1'b0, 7'd0, 6'd10);
    chk("run_modesel", ModeSel, 1);
    chk("run_running", Running, 1);

    // async reset between edges
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 7'd0, 6'd10);
    #2 RstN = 1'b0;
    #1;
    chk("areset_run", Running, 0);
    chk("areset_lsb", LSBBinary, 0);
    chk("areset_mode", ModeSel, 0);
    model_reset();
    @(negedge Clk);
    RstN = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 7'd0, 6'd0);
    chk("areset_idle", Running, 0);

    // up count saturates at 99:59
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 7'd0, 6'd0);
    repeat (23997) cyc(1'b0, 1'b0, 1'b0, 7'd0, 6'd0);
    chk("sat_msb", MSBBinary, 99);
    chk("sat_lsb", LSBBinary, 59);
    chk("sat_done", Done, 1);
    repeat (20) cyc(1'b0, 1'b0, 1'b0, 7'd0, 6'd0);
    chk("sat_hold_lsb", LSBBinary, 59);

    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic ss, clr, md;
      logic [6:0] pm;
      logic [5:0] ps;
      ss  = ($urandom % 6) == 0;
      clr = ($urandom % 60) == 0;
      md  = ($urandom % 2) == 1;
      pm  = (($urandom % 5) == 0) ? 7'($urandom_range(0, 127))
                                  : 7'($urandom_range(0, 1));
      ps  = 6'($urandom_range(0, 63));
      cyc(ss, clr, md, pm, ps);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
